// File: rtl/counter_scheduler_pkg.sv
// counter_scheduler_pkg: shared types and defaults for the counter scheduler.
//   sched_state_t : scheduler FSM state encoding (IDLE, RUN, DONE)
//   DEF_N / DEF_R : default counter width and requester count
//   PTR_W         : round-robin pointer width for the default requester count
package counter_scheduler_pkg;

    localparam int unsigned DEF_N = 3;
    localparam int unsigned DEF_R = 4;
    localparam int unsigned PTR_W = $clog2(DEF_R);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req    : request vector, one bit per requester
//   ptr    : index where the search starts (wraps modulo R)
//   winner : one-hot first asserted request at or after ptr (zero if none)
//   index  : binary index of the winner (zero if none)
module rr_pick #(
    parameter int unsigned R  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [R-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [R-1:0]  winner,
    output logic [PW-1:0] index
);

    logic        found;
    int unsigned j;

    always_comb begin
        winner = '0;
        index  = '0;
        found  = 1'b0;
        j      = 0;
        for (int unsigned off = 0; off < R; off++) begin
            j = (32'(ptr) + off) % R;
            if (!found && req[j]) begin
                found     = 1'b1;
                winner[j] = 1'b1;
                index     = PW'(j);
            end
        end
    end

endmodule

// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin time-sharing of one N-bit interval counter
// among R requesters.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   req   : per-requester level request, held until done or abort
//   term  : packed terminal counts, requester i uses term[i*N +: N]
//   grant : one-hot current owner (zero when idle)
//   busy  : high while any grant bit is set
//   count : current counter value
//   done  : one-hot single-cycle completion pulse to the owner
module counter_scheduler
    import counter_scheduler_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned R = DEF_R
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] term,
    output logic [R-1:0]   grant,
    output logic           busy,
    output logic [N-1:0]   count,
    output logic [R-1:0]   done
);

    localparam int unsigned PW = $clog2(R);

    sched_state_t  state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [N-1:0]  term_q;

    logic [R-1:0]  pick_onehot;
    logic [PW-1:0] pick_idx;
    logic [N-1:0]  pick_term;
    logic [PW-1:0] owner_next;

    rr_pick #(
        .R  (R),
        .PW (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_onehot),
        .index  (pick_idx)
    );

    assign pick_term  = term[pick_idx*N +: N];
    // Explicit wrap so non-power-of-two R never leaves ptr out of range.
    assign owner_next = (owner == PW'(R-1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            grant  <= '0;
            busy   <= 1'b0;
            count  <= '0;
            done   <= '0;
            ptr    <= '0;
            owner  <= '0;
            term_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (|req) begin
                        grant  <= pick_onehot;
                        busy   <= 1'b1;
                        owner  <= pick_idx;
                        term_q <= pick_term;
                        count  <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Abort outranks the terminal match in the same cycle.
                    if (!req[owner]) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        count <= '0;
                        ptr   <= owner_next;
                        state <= IDLE;
                    end else if (count == term_q) begin
                        done  <= grant;
                        state <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    done  <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                    count <= '0;
                    ptr   <= owner_next;
                    state <= IDLE;
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    done  <= '0;
                    count <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler: directed self-checking bench for counter_scheduler
// with N=3, R=4. Observed outputs are packed as {grant, busy, count, done}.
module tb_counter_scheduler;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] term;
    logic [3:0]  grant;
    logic        busy;
    logic [2:0]  count;
    logic [3:0]  done;

    logic [11:0] obs;
    logic [11:0] want;
    int          pass_cnt;
    int          total_cnt;

    counter_scheduler #(
        .N (3),
        .R (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .term  (term),
        .grant (grant),
        .busy  (busy),
        .count (count),
        .done  (done)
    );

    assign obs = {grant, busy, count, done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] ev(input logic [3:0] g, input logic [2:0] c, input logic [3:0] d);
        return {g, |g, c, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        term  = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = '0;
        term  = '0;
        #3;
        want = '0;
        if (obs !== want) $display("FAIL reset_initial: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
        @(negedge clk);
        reset = 1'b1;
        req  = 4'b0010;
        term = 12'hFFF;
        tick();
        want = ev(4'b0010, 3'd0, 4'b0000);
        if (obs !== want) $display("FAIL reset_first_grant: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
        repeat (9) tick();
        want = ev(4'b0000, 3'd0, 4'b0000);
        if (obs !== want) $display("FAIL reset_gap_idle: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
        tick();
        want = ev(4'b0010, 3'd0, 4'b0000);
        if (obs !== want) $display("FAIL reset_second_grant: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
        repeat (5) tick();
        want = ev(4'b0010, 3'd5, 4'b0000);
        if (obs !== want) $display("FAIL reset_midrun_count5: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
        // ptr is 2 here; after reset ptr=0 must pick requester 1, not 3.
        req = 4'b1010;
        #2;
        reset = 1'b0;
        #1;
        want = '0;
        if (obs !== want) $display("FAIL reset_async_clear: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
        #1;
        reset = 1'b1;
        tick();
        want = ev(4'b0010, 3'd0, 4'b0000);
        if (obs !== want) $display("FAIL reset_regrant_ptr0: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_single();
        do_reset();
        req  = 4'b0001;
        term = 12'd5;
        for (int k = 0; k <= 5; k++) begin
            tick();
            want = ev(4'b0001, 3'(k), 4'b0000);
            if (obs !== want) $display("FAIL single_run k=%0d: got %b want %b", k, obs, want); else pass_cnt++;
            total_cnt++;
        end
        tick();
        want = ev(4'b0001, 3'd5, 4'b0001);
        if (obs !== want) $display("FAIL single_done: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
        tick();
        want = ev(4'b0000, 3'd0, 4'b0000);
        if (obs !== want) $display("FAIL single_idle: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
        tick();
        want = ev(4'b0001, 3'd0, 4'b0000);
        if (obs !== want) $display("FAIL single_regrant: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_round_robin();
        logic [3:0] order [5];
        order[0] = 4'b0001;
        order[1] = 4'b0010;
        order[2] = 4'b0100;
        order[3] = 4'b1000;
        order[4] = 4'b0001;
        do_reset();
        req  = 4'b1111;
        term = 12'b001_001_001_001;
        for (int g = 0; g < 5; g++) begin
            tick();
            want = ev(order[g], 3'd0, 4'b0000);
            if (obs !== want) $display("FAIL rr_grant g=%0d: got %b want %b", g, obs, want); else pass_cnt++;
            total_cnt++;
            tick();
            want = ev(order[g], 3'd1, 4'b0000);
            if (obs !== want) $display("FAIL rr_count g=%0d: got %b want %b", g, obs, want); else pass_cnt++;
            total_cnt++;
            tick();
            want = ev(order[g], 3'd1, order[g]);
            if (obs !== want) $display("FAIL rr_done g=%0d: got %b want %b", g, obs, want); else pass_cnt++;
            total_cnt++;
            tick();
            want = ev(4'b0000, 3'd0, 4'b0000);
            if (obs !== want) $display("FAIL rr_idle g=%0d: got %b want %b", g, obs, want); else pass_cnt++;
            total_cnt++;
        end
    endtask

    task automatic test_abort();
        do_reset();
        req  = 4'b0100;
        term = 12'd6 << 6;
        for (int k = 0; k <= 3; k++) begin
            tick();
            want = ev(4'b0100, 3'(k), 4'b0000);
            if (obs !== want) $display("FAIL abort_run k=%0d: got %b want %b", k, obs, want); else pass_cnt++;
            total_cnt++;
        end
        req = 4'b1011;
        tick();
        want = ev(4'b0000, 3'd0, 4'b0000);
        if (obs !== want) $display("FAIL abort_clear: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
        tick();
        want = ev(4'b1000, 3'd0, 4'b0000);
        if (obs !== want) $display("FAIL abort_next_from3: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_boundaries();
        do_reset();
        req  = 4'b0001;
        term = 12'd0;
        tick();
        want = ev(4'b0001, 3'd0, 4'b0000);
        if (obs !== want) $display("FAIL term0_grant: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
        tick();
        want = ev(4'b0001, 3'd0, 4'b0001);
        if (obs !== want) $display("FAIL term0_done: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
        tick();
        want = ev(4'b0000, 3'd0, 4'b0000);
        if (obs !== want) $display("FAIL term0_release: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;

        do_reset();
        req  = 4'b0001;
        term = 12'd7;
        for (int k = 0; k <= 7; k++) begin
            tick();
            want = ev(4'b0001, 3'(k), 4'b0000);
            if (obs !== want) $display("FAIL term7_run k=%0d: got %b want %b", k, obs, want); else pass_cnt++;
            total_cnt++;
        end
        tick();
        want = ev(4'b0001, 3'd7, 4'b0001);
        if (obs !== want) $display("FAIL term7_done_nowrap: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
        tick();
        want = ev(4'b0000, 3'd0, 4'b0000);
        if (obs !== want) $display("FAIL term7_release: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        req  = 4'b0001;
        term = 12'd2;
        repeat (3) tick();
        want = ev(4'b0001, 3'd2, 4'b0000);
        if (obs !== want) $display("FAIL simul_at_term: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
        req = 4'b0000;
        tick();
        want = ev(4'b0000, 3'd0, 4'b0000);
        if (obs !== want) $display("FAIL simul_abort_no_done: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
        tick();
        want = ev(4'b0000, 3'd0, 4'b0000);
        if (obs !== want) $display("FAIL simul_stays_idle: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;

        do_reset();
        req  = 4'b0001;
        term = 12'd5;
        repeat (2) tick();
        term = 12'd2;
        for (int k = 2; k <= 5; k++) begin
            tick();
            want = ev(4'b0001, 3'(k), 4'b0000);
            if (obs !== want) $display("FAIL term_change_run k=%0d: got %b want %b", k, obs, want); else pass_cnt++;
            total_cnt++;
        end
        tick();
        want = ev(4'b0001, 3'd5, 4'b0001);
        if (obs !== want) $display("FAIL term_change_done: got %b want %b", obs, want); else pass_cnt++;
        total_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b0;
        req       = '0;
        term      = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_boundaries();
        test_simultaneous();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/counter_scheduler.md
# counter_scheduler

Round-robin scheduler that time-shares one N-bit up-counter, used as an interval timer, between R requesters. Each requester raises `req` and presents a terminal count. The scheduler grants the counter to one requester, runs it from 0 to that terminal count, pulses `done` to the owner, then re-arbitrates. It sits between client FSMs that need timed waits and the shared counter datapath.

## Interface
- `N`, default 3: counter width in bits; terminal counts are N bits.
- `R`, default 4: number of requesters (R ≥ 2).

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `req`, input, R: request per requester. Level-sensitive; must be held until `done` or abort.
- `term`, input, R*N: packed terminal counts; requester i uses `term[i*N +: N]`.
- `grant`, output, R: one-hot owner of the counter; all zero when idle.
- `busy`, output, 1: high whenever `grant` is nonzero.
- `count`, output, N: current counter value.
- `done`, output, R: one-hot, single-cycle completion pulse to the owner.

## Operation
- Reset (asynchronous, `reset`=0) immediately forces state IDLE and clears `grant`, `busy`, `count`, `done`, and the round-robin pointer `ptr`. All of these are 0 at reset.
- The state machine has three states: IDLE, RUN, DONE.
- **IDLE**
  - If `req`≠0, select the winner: the first asserted bit searching from `ptr` upward, wrapping modulo R.
  - Register the winner's `grant` bit and latch its `term` into `term_q`.
  - Set `count`=0 and go to RUN.
  - If `req`=0, remain in IDLE.
- **RUN**
  - If `req[owner]`=0, abort: go to IDLE, clear `grant`, no `done` pulse, and set `ptr`=owner+1.
  - Otherwise, if `count`==`term_q`, go to DONE.
  - Otherwise, increment `count` by 1.
  - Abort has priority over the terminal match when both occur in the same cycle.
- **DONE**
  - `done[owner]`=1 for exactly this one cycle.
  - `grant` stays high and `count` holds at `term_q`.
  - The next state is unconditionally IDLE: clear `grant`, set `ptr`=(owner+1) mod R, set `count`=0.
  - Dropping `req` in DONE does not suppress `done`.
- Changes to `term` after grant are ignored, because `term_q` is frozen for the whole grant.
- `count` never wraps: it stops at `term_q` ≤ 2^N−1. With `term`=2^N−1, the counter reaches all-ones with no overflow.
- With `term`=0, the grant spends one RUN cycle at `count`=0, then enters DONE.
- Grants are granted one at a time; only one `grant` bit and at most one `done` bit are ever high.

## Timing
- Requests are sampled at edge E0. The scheduler must be in IDLE at E0.
- `grant`/`busy` rise at E0, with `count`=0.
- `count`=k after edge E0+k, for k ≤ T (where T is the latched terminal count).
- DONE is entered at E0+T+1, so `done` is high between E0+T+1 and E0+T+2.
- `grant` falls at E0+T+2.
- Total grant length is T+2 cycles.
- At least one IDLE cycle separates consecutive grants, so the next winner's `grant` rises at E0+T+3 at the earliest.
- All outputs are registered; there is no combinational path from `req` or `term` to any output.

## Structure
- Package `counter_scheduler_pkg` holds:
  - typedef enum `sched_state_t` {IDLE=2'b00, RUN=2'b01, DONE=2'b10};
  - a localparam for the pointer width, $clog2(R).
- Sub-module `rr_pick`, combinational: inputs `req` and `ptr`; outputs a one-hot winner and its index. It is instantiated once.
- The counter register, `term_q` mux, and FSM live in `counter_scheduler`.

## Test plan
All scenarios use N=3, R=4.
- **Reset values.** Assert `reset`=0 mid-RUN with `count`=5 → all outputs are 0 immediately, before the next edge. On release, a held `req` is regranted from `ptr`=0.
- **Single requester.** `req`=0001, `term[0]`=5 → `grant`=0001 for 7 cycles; `count` runs 0,1,2,3,4,5,5; `done`=0001 for one cycle on the second 5; one IDLE cycle, then regrant.
- **Round-robin fairness.** `req`=1111 held, all `term`=1 → grants occur in the order 0001, 0010, 0100, 1000, 0001. Each grant lasts 3 cycles, followed by 1 IDLE cycle.
- **Abort.** `req`=0100, `term[2]`=6; drop `req[2]` when `count`=3 → `grant` clears at the next edge, `done` never pulses, and the next grant starts search at index 3.
- **Boundaries.**
  - `term`=0 → `count` stays 0, `done` asserts on the 2nd grant cycle.
  - `term`=7 → `count` reaches 7 with no wrap to 0 during the grant.
- **Simultaneous events.**
  - Drop `req` on the same cycle `count`==`term_q` → abort, no `done`.
  - Change `term[owner]` mid-RUN from 5 to 2 → completion still occurs at 5.
